// File: rtl/tile_cfg_bank_loader.sv
// Tile configuration bank loader: parses framed config stream, writes
// local or broadcast rows into the bank and forwards foreign frames.
module tile_cfg_bank_loader #(
  parameter int BL_WIDTH = 315,
  parameter int WL_ROWS  = 4,
  parameter int DATA_W   = 32,
  parameter int TILE_ID  = 0,
  parameter int WL_PULSE = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_in_valid,
  output logic                cfg_in_ready,
  input  logic [DATA_W-1:0]   cfg_in_data,
  output logic                cfg_out_valid,
  input  logic                cfg_out_ready,
  output logic [DATA_W-1:0]   cfg_out_data,
  output logic [BL_WIDTH-1:0] bl,
  output logic [WL_ROWS-1:0]  wl,
  output logic                busy,
  output logic                err,
  output logic [15:0]         rows_written
);

  localparam int NBEATS = (BL_WIDTH + DATA_W - 1) / DATA_W;
  localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PW = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;
  localparam logic [BW-1:0] LAST  = BW'(NBEATS - 1);
  localparam logic [PW-1:0] PLAST = PW'(WL_PULSE - 1);
  localparam logic [7:0]    MY_ID = 8'(TILE_ID);

  typedef enum logic [2:0] {
    IDLE, LOAD, FWD, BCAST, DROP, WRITE
  } state_e;

  state_e              state_q;
  logic [BW-1:0]       beat_q;
  logic [PW-1:0]       pcnt_q;
  logic [7:0]          row_q;
  logic [BL_WIDTH-1:0] rowbuf_q, rowbuf_d;
  logic [BL_WIDTH-1:0] bl_q;
  logic [WL_ROWS-1:0]  wl_q, row_oh;
  logic                ov_q;
  logic [DATA_W-1:0]   od_q;
  logic                err_q;
  logic [15:0]         rw_q;

  logic [7:0] hdr_id, hdr_row;
  logic       row_ok, is_local, is_bcast;
  logic       in_rdy, in_fire, out_free, fwd_fire, last_beat;

  assign hdr_id    = cfg_in_data[DATA_W-1 -: 8];
  assign hdr_row   = cfg_in_data[7:0];
  assign row_ok    = {1'b0, hdr_row} < 9'(WL_ROWS);
  assign is_local  = hdr_id == MY_ID;
  assign is_bcast  = (hdr_id == 8'hFF) && row_ok;
  assign out_free  = !ov_q || cfg_out_ready;
  assign in_fire   = cfg_in_valid && in_rdy;
  assign last_beat = beat_q == LAST;

  always_comb begin
    in_rdy = 1'b0;
    unique case (state_q)
      IDLE, FWD, BCAST: in_rdy = out_free;
      LOAD, DROP:       in_rdy = 1'b1;
      default:          in_rdy = 1'b0;
    endcase
  end

  assign fwd_fire = in_fire &&
    ((state_q == IDLE && !is_local) ||
     state_q == FWD || state_q == BCAST);

  // Each bit of the row maps to a fixed beat and lane; tail lanes drop.
  always_comb begin
    rowbuf_d = rowbuf_q;
    for (int j = 0; j < BL_WIDTH; j++) begin
      if (beat_q == BW'(j / DATA_W))
        rowbuf_d[j] = cfg_in_data[j % DATA_W];
    end
  end

  always_comb begin
    row_oh = '0;
    for (int i = 0; i < WL_ROWS; i++)
      row_oh[i] = (row_q == 8'(i));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      pcnt_q   <= '0;
      row_q    <= '0;
      rowbuf_q <= '0;
      bl_q     <= '0;
      wl_q     <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      err_q    <= 1'b0;
      rw_q     <= '0;
    end else begin
      if (fwd_fire) begin
        ov_q <= 1'b1;
        od_q <= cfg_in_data;
      end else if (cfg_out_ready) begin
        ov_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (in_fire) begin
            beat_q <= '0;
            row_q  <= hdr_row;
            if (is_local && row_ok) begin
              state_q <= LOAD;
            end else if (is_local) begin
              state_q <= DROP;
              err_q   <= 1'b1;
            end else if (is_bcast) begin
              state_q <= BCAST;
            end else begin
              state_q <= FWD;
            end
          end
        end
        LOAD, BCAST: begin
          if (in_fire) begin
            rowbuf_q <= rowbuf_d;
            beat_q   <= beat_q + 1'b1;
            if (last_beat) begin
              state_q <= WRITE;
              bl_q    <= rowbuf_d;
              wl_q    <= row_oh;
              pcnt_q  <= '0;
            end
          end
        end
        FWD, DROP: begin
          if (in_fire) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) state_q <= IDLE;
          end
        end
        WRITE: begin
          if (pcnt_q == PLAST) begin
            wl_q    <= '0;
            state_q <= IDLE;
            if (rw_q != 16'hFFFF) rw_q <= rw_q + 16'd1;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_in_ready  = in_rdy;
  assign cfg_out_valid = ov_q;
  assign cfg_out_data  = od_q;
  assign bl            = bl_q;
  assign wl            = wl_q;
  assign busy          = state_q != IDLE;
  assign err           = err_q;
  assign rows_written  = rw_q;

endmodule

// File: tb/tb_tile_cfg_bank_loader.sv
// Bench for tile_cfg_bank_loader: vector table, directed corner cases
// and random frames against a frame-level reference model.
module tb_tile_cfg_bank_loader;

  localparam int BLW = 40;
  localparam int WLR = 4;
  localparam int DW  = 16;
  localparam int TID = 3;
  localparam int WLP = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cfg_in_valid = 1'b0;
  logic           cfg_in_ready;
  logic [DW-1:0]  cfg_in_data = '0;
  logic           cfg_out_valid;
  logic           cfg_out_ready = 1'b1;
  logic [DW-1:0]  cfg_out_data;
  logic [BLW-1:0] bl;
  logic [WLR-1:0] wl;
  logic           busy;
  logic           err;
  logic [15:0]    rows_written;

  always #5 clk = ~clk;

  tile_cfg_bank_loader #(
    .BL_WIDTH(BLW), .WL_ROWS(WLR), .DATA_W(DW),
    .TILE_ID(TID), .WL_PULSE(WLP)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_in_valid(cfg_in_valid), .cfg_in_ready(cfg_in_ready),
    .cfg_in_data(cfg_in_data),
    .cfg_out_valid(cfg_out_valid), .cfg_out_ready(cfg_out_ready),
    .cfg_out_data(cfg_out_data),
    .bl(bl), .wl(wl), .busy(busy), .err(err),
    .rows_written(rows_written)
  );

  typedef struct packed {
    logic [7:0]     row;
    logic [BLW-1:0] data;
  } wr_t;

  typedef struct {
    logic [15:0]    hdr;
    logic [15:0]    p0, p1, p2;
    bit             fwd;
    bit             wr;
    logic [BLW-1:0] bl;
    bit             err;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int rmode = 1;
  logic [15:0] q_out[$];
  wr_t q_wr[$];
  logic [BLW-1:0] m_bl = '0;
  bit m_err = 1'b0;
  int m_rw = 0;
  vec_t tv[8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    int n;
    n = 0;
    cfg_in_valid = 1'b1;
    cfg_in_data = w;
    @(negedge clk);
    while (!cfg_in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("in_handshake", 64'(cfg_in_ready), 64'd1);
    align();
    cfg_in_valid = 1'b0;
    cfg_in_data = 16'($urandom);
  endtask

  task automatic send_frame(input logic [15:0] h, p0, p1, p2,
                            input bit gaps);
    logic [15:0] w[4];
    w = '{h, p0, p1, p2};
    for (int k = 0; k < 4; k++) begin
      send_word(w[k]);
      if (gaps) repeat ($urandom_range(0, 2)) align();
    end
  endtask

  function automatic void model_frame(input logic [15:0] h, p0, p1, p2);
    logic [7:0] id;
    logic [7:0] row;
    bit wr;
    id = h[15:8];
    row = h[7:0];
    wr = 1'b0;
    if (id == 8'(TID)) begin
      if (int'(row) < WLR) wr = 1'b1;
      else m_err = 1'b1;
    end else begin
      q_out.push_back(h);
      q_out.push_back(p0);
      q_out.push_back(p1);
      q_out.push_back(p2);
      if (id == 8'hFF && int'(row) < WLR) wr = 1'b1;
    end
    if (wr) begin
      m_bl = {p2[7:0], p1, p0};
      q_wr.push_back({row, m_bl});
      if (m_rw < 65535) m_rw++;
    end
  endfunction

  task automatic settle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    n = 0;
    while (q_out.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_drain"}, 64'(q_out.size()), 64'd0);
    chk({tag, "_writes"}, 64'(q_wr.size()), 64'd0);
    chk({tag, "_bl"}, 64'(bl), 64'(m_bl));
    chk({tag, "_err"}, 64'(err), 64'(m_err));
    chk({tag, "_rows"}, 64'(rows_written), 64'(m_rw));
    align();
  endtask

  initial begin
    tv[0] = '{16'h0302, 16'h1111, 16'h2222, 16'h0033,
              1'b0, 1'b1, 40'h33_2222_1111, 1'b0};
    tv[1] = '{16'h0501, 16'h0A0A, 16'h0B0B, 16'h0C0C,
              1'b1, 1'b0, 40'h33_2222_1111, 1'b0};
    tv[2] = '{16'hFF00, 16'hAAAA, 16'hBBBB, 16'h00CC,
              1'b1, 1'b1, 40'hCC_BBBB_AAAA, 1'b0};
    tv[3] = '{16'h0307, 16'hDEAD, 16'hBEEF, 16'h0F0F,
              1'b0, 1'b0, 40'hCC_BBBB_AAAA, 1'b1};
    tv[4] = '{16'h0301, 16'h1234, 16'h5678, 16'hAB9A,
              1'b0, 1'b1, 40'h9A_5678_1234, 1'b1};
    tv[5] = '{16'hFF05, 16'h5555, 16'h6666, 16'h7777,
              1'b1, 1'b0, 40'h9A_5678_1234, 1'b1};
    tv[6] = '{16'h0303, 16'hFFFF, 16'hFFFF, 16'hFFFF,
              1'b0, 1'b1, 40'hFF_FFFF_FFFF, 1'b1};
    tv[7] = '{16'h03FF, 16'h0001, 16'h0002, 16'h0003,
              1'b0, 1'b0, 40'hFF_FFFF_FFFF, 1'b1};

    fork
      forever begin
        @(posedge clk);
        #2;
        case (rmode)
          0: cfg_out_ready = 1'b0;
          1: cfg_out_ready = 1'b1;
          default: cfg_out_ready = ($urandom_range(0, 3) != 0);
        endcase
      end
      begin : mon
        int plen;
        wr_t w;
        plen = 0;
        forever begin
          @(negedge clk);
          if (!reset) begin
            plen = 0;
          end else begin
            if (cfg_out_valid && cfg_out_ready) begin
              if (q_out.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL out_unexpected: got %h expected none",
                         cfg_out_data);
              end else begin
                chk("out_word", 64'(cfg_out_data), 64'(q_out.pop_front()));
              end
            end
            if (wl != '0) begin
              if (plen == 0) begin
                if (q_wr.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL wl_unexpected: got %b expected 0", wl);
                end else begin
                  w = q_wr.pop_front();
                  chk("wl_row", 64'(wl), 64'(1) << w.row);
                  chk("bl_write", 64'(bl), 64'(w.data));
                end
              end
              plen++;
            end else if (plen != 0) begin
              chk("wl_len", 64'(plen), 64'(WLP));
              plen = 0;
            end
          end
        end
      end
    join_none

    repeat (2) align();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wl", 64'(wl), 64'd0);
    chk("rst_bl", 64'(bl), 64'd0);
    chk("rst_ovalid", 64'(cfg_out_valid), 64'd0);
    chk("rst_odata", 64'(cfg_out_data), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rows", 64'(rows_written), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    align();
    chk("ready_after_rst", 64'(cfg_in_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      if (tv[i].fwd) begin
        q_out.push_back(tv[i].hdr);
        q_out.push_back(tv[i].p0);
        q_out.push_back(tv[i].p1);
        q_out.push_back(tv[i].p2);
      end
      if (tv[i].wr) begin
        q_wr.push_back({tv[i].hdr[7:0], tv[i].bl});
        m_rw++;
      end
      m_bl = tv[i].bl;
      m_err = tv[i].err;
      send_frame(tv[i].hdr, tv[i].p0, tv[i].p1, tv[i].p2, 1'b0);
      settle($sformatf("vec%0d", i));
    end

    // Downstream stalled while a foreign frame arrives.
    rmode = 0;
    model_frame(16'h0501, 16'h4444, 16'h5555, 16'h6666);
    fork
      send_frame(16'h0501, 16'h4444, 16'h5555, 16'h6666, 1'b0);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!cfg_out_valid && n < 20) begin
          n++;
          @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
          chk("bp_data", 64'(cfg_out_data), 64'h0501);
          chk("bp_valid", 64'(cfg_out_valid), 64'd1);
          chk("bp_inrdy", 64'(cfg_in_ready), 64'd0);
          chk("bp_wl", 64'(wl), 64'd0);
          @(negedge clk);
        end
        rmode = 1;
      end
    join
    settle("bp");

    // Reset in the middle of a local frame.
    send_word(16'h0300);
    send_word(16'h7777);
    send_word(16'h8888);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_bl", 64'(bl), 64'd0);
    chk("mid_wl", 64'(wl), 64'd0);
    chk("mid_ovalid", 64'(cfg_out_valid), 64'd0);
    chk("mid_odata", 64'(cfg_out_data), 64'd0);
    chk("mid_err", 64'(err), 64'd0);
    chk("mid_rows", 64'(rows_written), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    q_out.delete();
    q_wr.delete();
    m_bl = '0;
    m_err = 1'b0;
    m_rw = 0;
    @(negedge clk);
    reset = 1'b1;
    align();
    model_frame(16'h0301, 16'h0102, 16'h0304, 16'h0506);
    send_frame(16'h0301, 16'h0102, 16'h0304, 16'h0506, 1'b0);
    settle("post_rst");

    rmode = 2;
    for (int f = 0; f < 80; f++) begin
      logic [7:0] id;
      logic [15:0] h, p0, p1, p2;
      case ($urandom_range(0, 3))
        0, 1: id = 8'(TID);
        2: id = 8'hFF;
        default: id = 8'($urandom);
      endcase
      h = {id, 8'($urandom_range(0, 6))};
      p0 = 16'($urandom);
      p1 = 16'($urandom);
      p2 = 16'($urandom);
      model_frame(h, p0, p1, p2);
      send_frame(h, p0, p1, p2, 1'b1);
      settle($sformatf("rnd%0d", f));
    end
    rmode = 1;
    settle("final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
